// File: rtl/ucsbece154b_dcache_pkg.sv
// ucsbece154b_dcache_pkg: FSM state encoding and address-field width helpers
package ucsbece154b_dcache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2} state_t;
  function automatic int word_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction
  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_bits(input int num_lines, input int words_per_line);
    return 30 - $clog2(num_lines) - $clog2(words_per_line);
  endfunction
endpackage

// File: rtl/ucsbece154b_dcache_array.sv
// ucsbece154b_dcache_array: tag/valid/data storage, combinational lookup, one synchronous write port
// Addresses are word addresses (byte address bits [31:2]).
module ucsbece154b_dcache_array
  import ucsbece154b_dcache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] i_raddr,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  input  logic [29:0] i_waddr,
  input  logic        i_tag_we,
  input  logic        i_data_we,
  input  logic [31:0] i_wdata
);
  localparam int W = word_bits(WORDS_PER_LINE);
  localparam int I = index_bits(NUM_LINES);
  localparam int T = tag_bits(NUM_LINES, WORDS_PER_LINE);
  logic [NUM_LINES-1:0] r_valid;
  logic [T-1:0]         r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];
  logic [I-1:0]         w_ridx, w_widx;
  logic [W-1:0]         w_rword, w_wword;
  assign w_ridx  = i_raddr[W +: I];
  assign w_rword = i_raddr[W-1:0];
  assign w_widx  = i_waddr[W +: I];
  assign w_wword = i_waddr[W-1:0];
  assign o_hit   = r_valid[w_ridx] && r_tag[w_ridx] == i_raddr[29 -: T];
  assign o_rdata = r_data[w_ridx][w_rword];
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_valid <= '0;
    else if (i_tag_we) r_valid[w_widx] <= 1'b1;
  // Tag and data carry no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[w_widx] <= i_waddr[29 -: T];
    if (i_data_we) r_data[w_widx][w_wword] <= i_wdata;
  end
endmodule

// File: rtl/ucsbece154b_dcache.sv
// ucsbece154b_dcache: direct-mapped, write-through, no-write-allocate data cache with refill/write FSM.
// Define DCACHE_STATS_EN to add hit_count_o/miss_count_o read-lookup counters.
module ucsbece154b_dcache
  import ucsbece154b_dcache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM_i,
  input  logic        MemWriteM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);
  localparam int W = word_bits(WORDS_PER_LINE);
  state_t      r_state, w_next;
  logic [W-1:0] r_beat;
  logic        w_hit, w_tag_we, w_data_we, w_last, w_unused;
  logic [31:0] w_word;
  logic [29:0] w_waddr;
  assign w_unused = &{1'b0, ALUResultM_i[1:0]};
  assign w_last   = r_beat == W'(WORDS_PER_LINE - 1);
  // The write port and the bus share one address: the beat replaces the word select during refill.
  assign w_waddr  = r_state == REFILL ? {ALUResultM_i[31:W+2], r_beat} : ALUResultM_i[31:2];
  ucsbece154b_dcache_array #(
    .NUM_LINES(NUM_LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_array (
    .clk(clk),
    .reset(reset),
    .i_raddr(ALUResultM_i[31:2]),
    .o_hit(w_hit),
    .o_rdata(w_word),
    .i_waddr(w_waddr),
    .i_tag_we(w_tag_we),
    .i_data_we(w_data_we),
    .i_wdata(r_state == REFILL ? mem_rdata_i : WriteDataM_i)
  );
  assign ReadDataM_o = w_hit ? w_word : 32'd0;
  assign mem_addr_o  = mem_req_o ? {w_waddr, 2'b00} : 32'd0;
  always_comb begin
    w_next      = r_state;
    StallM_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 32'd0;
    w_tag_we    = 1'b0;
    w_data_we   = 1'b0;
    case (r_state)
      IDLE: begin
        StallM_o = MemWriteM_i || (MemReadM_i && !w_hit);
        w_next   = MemWriteM_i ? WRITE : (MemReadM_i && !w_hit) ? REFILL : IDLE;
      end
      REFILL: begin
        StallM_o  = 1'b1;
        mem_req_o = 1'b1;
        w_data_we = mem_ready_i;
        w_tag_we  = mem_ready_i && w_last;
        w_next    = w_tag_we ? IDLE : REFILL;
      end
      WRITE: begin
        StallM_o    = !mem_ready_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = WriteDataM_i;
        w_data_we   = mem_ready_i && w_hit;
        w_next      = mem_ready_i ? IDLE : WRITE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      r_beat  <= r_state != REFILL ? '0 : r_beat + W'(mem_ready_i);
    end
`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        r_refilled, w_lookup;
  assign w_lookup     = r_state == IDLE && MemReadM_i && !MemWriteM_i;
  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
  // The hit that follows a refill belongs to the access already counted as a miss.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
      r_refilled <= 1'b0;
    end else begin
      r_refilled <= w_tag_we;
      if (w_lookup && !w_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_lookup && w_hit && !r_refilled) r_hit_cnt <= r_hit_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ucsbece154b_dcache.sv
// tb_ucsbece154b_dcache: directed scoreboard bench for the direct-mapped write-through data cache
module tb_ucsbece154b_dcache;
  logic        clk = 1'b0, reset = 1'b0;
  logic        MemReadM_i = 1'b0, MemWriteM_i = 1'b0;
  logic [31:0] ALUResultM_i = 32'd0, WriteDataM_i = 32'd0;
  logic [31:0] ReadDataM_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        StallM_o, mem_req_o, mem_we_o, mem_ready_i;
  int compared = 0, mismatched = 0;
  int lat = 0, wcnt = 0;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} beat_t;
  beat_t       bus_q[$];
  beat_t       mon_b;
  logic [31:0] rd_q[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  always #5 clk = ~clk;

  ucsbece154b_dcache dut (
    .clk(clk), .reset(reset),
    .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .ReadDataM_o(ReadDataM_o), .StallM_o(StallM_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  // Backing memory: 0x100 line reads 0xA0..0xA3, 0x200 line reads 0xB0..0xB3.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return 32'h90 + {24'd0, a[11:8], 4'h0} + {30'd0, a[3:2]};
  endfunction

  assign mem_rdata_i = mem_model(mem_addr_o);
  assign mem_ready_i = mem_req_o && wcnt >= lat;
  always @(posedge clk) wcnt <= (mem_req_o && !mem_ready_i) ? wcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_wait) begin
      chk("bus_hold_req", {31'd0, mem_req_o}, 32'd1);
      chk("bus_hold_addr", mem_addr_o, prev_addr);
    end
    prev_wait <= mem_req_o && !mem_ready_i;
    prev_addr <= mem_addr_o;
    if (mem_req_o && mem_ready_i) begin
      chk("bus_expected", {31'd0, bus_q.size() > 0}, 32'd1);
      if (bus_q.size() > 0) begin
        mon_b = bus_q.pop_front();
        chk("bus_addr", mem_addr_o, mon_b.addr);
        chk("bus_we", {31'd0, mem_we_o}, {31'd0, mon_b.we});
        chk("bus_wdata", mem_wdata_o, mon_b.wdata);
      end
    end
  end

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bus_q.push_back('{a, we, wd});
  endtask

  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) push_bus(base + 32'(4 * k), 1'b0, 32'd0);
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_stall, input logic [31:0] exp_rd);
    int n = 0;
    logic [31:0] e;
    @(posedge clk); #2;
    MemReadM_i = rd; MemWriteM_i = wr; ALUResultM_i = a; WriteDataM_i = wd;
    if (rd && !wr) rd_q.push_back(exp_rd);
    @(negedge clk);
    while (StallM_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
    if (rd && !wr) begin
      e = rd_q.pop_front();
      chk({tag, "_rdata"}, ReadDataM_o, e);
    end
    @(posedge clk); #2;
    MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_stall", {31'd0, StallM_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", ReadDataM_o, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    fill(32'h100);
    access("cold_miss", 1'b1, 1'b0, 32'h100, 32'd0, 5, 32'hA0);
    access("hit_108", 1'b1, 1'b0, 32'h108, 32'd0, 0, 32'hA2);
    lat = 2;
    push_bus(32'h104, 1'b1, 32'hDEADBEEF);
    access("store_hit", 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 3, 32'd0);
    lat = 0;
    access("read_after_store", 1'b1, 1'b0, 32'h104, 32'd0, 0, 32'hDEADBEEF);
    lat = 1;
    push_bus(32'h204, 1'b1, 32'h12345678);
    access("store_miss", 1'b0, 1'b1, 32'h204, 32'h12345678, 2, 32'd0);
    lat = 0;
    access("hit_after_store_miss", 1'b1, 1'b0, 32'h104, 32'd0, 0, 32'hDEADBEEF);
    fill(32'h200);
    access("evict_200", 1'b1, 1'b0, 32'h200, 32'd0, 5, 32'hB0);
    fill(32'h100);
    access("reread_100", 1'b1, 1'b0, 32'h100, 32'd0, 5, 32'hA0);
    push_bus(32'h108, 1'b1, 32'hCAFEF00D);
    access("rw_both", 1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 1, 32'd0);
    access("read_rw_word", 1'b1, 1'b0, 32'h108, 32'd0, 0, 32'hCAFEF00D);
    push_bus(32'h200, 1'b0, 32'd0);
    push_bus(32'h204, 1'b0, 32'd0);
    @(posedge clk); #2;
    MemReadM_i = 1'b1; ALUResultM_i = 32'h200;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0; MemReadM_i = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mid_stall", {31'd0, StallM_o}, 32'd0);
    chk("rst_mid_addr", mem_addr_o, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    fill(32'h100);
    access("miss_after_reset", 1'b1, 1'b0, 32'h100, 32'd0, 5, 32'hA0);
    repeat (2) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_dcache.md
# ucsbece154b_dcache

Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's Memory stage and the main-memory bus. Accepts the M-stage address, write data and control. Returns read data combinationally on a hit, and holds the pipeline with `StallM_o` while it refills a line or completes a write-through.

## Interface
Parameters:
- `NUM_LINES`, 16: number of cache lines; power of 2, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of 2, ≥2.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `MemReadM_i`  input  1  M-stage load.
- `MemWriteM_i`  input  1  M-stage store.
- `ALUResultM_i`  input  32  byte address.
- `WriteDataM_i`  input  32  store data.
- `ReadDataM_o`  output  32  load data; valid when `StallM_o`=0.
- `StallM_o`  output  1  holds the F/D/E/M registers and bubbles W.
- `mem_req_o`  output  1  bus request.
- `mem_we_o`  output  1  bus write.
- `mem_addr_o`  output  32  word-aligned bus address.
- `mem_wdata_o`  output  32  bus write data.
- `mem_ready_i`  input  1  beat accepted; read data is valid in the same cycle.
- `mem_rdata_i`  input  32  bus read data.

## Operation
Address fields:
- `[1:0]` is the byte offset, ignored; word accesses only.
- `[W+1:2]` is the word select, where W=log2(WORDS_PER_LINE).
- The next log2(NUM_LINES) bits are the index.
- The remaining bits are the tag.

FSM states are IDLE, REFILL and WRITE.
- **IDLE, read hit:**
  - `ReadDataM_o` is taken from the array combinationally; `StallM_o`=0.
- **IDLE, read miss:**
  - `StallM_o`=1.
  - Beat counter cleared.
  - Next state REFILL.
- **IDLE, write (hit or miss):**
  - `StallM_o`=1.
  - Next state WRITE.
  - A write has priority if `MemReadM_i` and `MemWriteM_i` are both 1.
- **REFILL:**
  - Drives `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={tag,index,beat,2'b00}.
  - On each `mem_ready_i`, writes `mem_rdata_i` into the data word and increments the beat.
  - On the last beat, writes the tag, sets valid and goes to IDLE. The held load then hits on the following cycle.
  - `StallM_o`=1 throughout.
- **WRITE:**
  - Drives `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={ALUResultM_i[31:2],2'b00}, `mem_wdata_o`=`WriteDataM_i`.
  - `StallM_o`=!`mem_ready_i`.
  - On `mem_ready_i`: if the line is valid and the tag matches, the cached word is updated; the next state is IDLE.
  - A miss does not allocate.
- **Neither access:** `StallM_o`=0, no bus activity.

## Timing
- **Reset values:** state IDLE, all valid bits 0, beat counter 0. `StallM_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `ReadDataM_o` are all 0.
- **Reset mid-REFILL:** the line stays invalid, the request drops immediately, and the partial data is discarded.
- **Latency:**
  - Hit load: 0 stall cycles.
  - Miss load: 1 + (WORDS_PER_LINE beats, each lasting until `mem_ready_i`) + 1 hit cycle.
  - Store: 1 + wait cycles until `mem_ready_i`.
- **Bus hold:** `mem_req_o` and `mem_addr_o` stay stable until `mem_ready_i`, with no gaps between beats.
- **Beat counter wrap:** the counter is W bits and wraps to 0 on the last beat.

## Configuration
- **`DCACHE_STATS_EN` defined:** adds output ports `hit_count_o` [31:0] and `miss_count_o` [31:0].
  - Each counts IDLE-state read lookups for which `StallM_o` would be 0 or 1 respectively, once per access rather than per stall cycle.
  - Both wrap modulo 2^32 and reset to 0.
- **Undefined:** the ports and counters are absent, with no other behavioural change.

## Structure
- **`ucsbece154b_dcache_pkg`:** state encoding localparams (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2) and functions deriving the index/word/tag widths from the parameters.
- **Sub-module `ucsbece154b_dcache_array`:**
  - Tag, valid and data storage.
  - Combinational read port: returns hit and word for a given address.
  - Synchronous single write port, with separate tag/valid and data-word enables.
  - Async-active-low clear of the valid bits.
- **Top level:** FSM, beat counter, bus drive, stall and optional statistics.

## Test plan
- **Cold read miss:** read 0x100 after reset, bus returns 0xA0..0xA3 with `mem_ready_i` always high → 4 bus reads at 0x100/0x104/0x108/0x10C, `StallM_o` high for 5 cycles, then `ReadDataM_o`=0xA0.
- **Hit after fill:** read 0x108 → `ReadDataM_o`=0xA2, no bus request, `StallM_o`=0.
- **Store hit, ready after 3 cycles:** store 0xDEADBEEF to 0x104 → bus write at 0x104 held for 3 cycles, stall released in the ready cycle, later read of 0x104 returns 0xDEADBEEF with no bus access.
- **Store miss then read:** store to 0x204 (same index as 0x104, different tag) → bus write only, then read 0x104 still hits.
- **Conflict eviction:** read 0x200 after the 0x100 fill → refill at 0x200..0x20C, then read 0x100 misses again.
- **Reset mid-refill:** assert `reset` after 2 beats → `mem_req_o` drops immediately; after release, read 0x100 misses.
